scan_data_selector: RTL and testbench
=====================================

Name: scan_data_selector

Overview:
Parametrised successor to the fixed 8:1 one-bit data selector. Selects one of CH channels, each W bits wide, into a registered output with a valid/ready handshake. Two modes:
- Direct: the external address chooses the channel.
- Scan: an internal FSM walks channels 0..CH-1, presenting one per accepted transfer.
Sits between parallel sample sources and a single serial consumer (display/UART framer).

Parameters:
CH, 8, number of input channels (>=2)
W, 8, bit width of each channel
AW, $clog2(CH), localparam; address/channel-index width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
dat  in  CH*W  packed channel data; channel k = dat[k*W +: W]
addr  in  AW  channel select in direct mode
mode  in  1  0 = direct, 1 = scan; sampled only in IDLE
start  in  1  single-cycle pulse; begins a scan when in IDLE with mode=1
out_data  out  W  selected channel data, registered
out_ch  out  AW  index of the channel currently in out_data
out_valid  out  1  out_data/out_ch valid
out_ready  in  1  consumer accepts when out_valid && out_ready
busy  out  1  high while in SCAN
done  out  1  one-cycle pulse after the last scan transfer

Behaviour:
- Reset (async, rst=1):
  - out_data=0, out_ch=0, out_valid=0, busy=0, done=0.
  - FSM goes to IDLE; scan counter = 0.
  - Mid-scan reset abandons the scan with no done pulse.
- Output register load condition: load = !out_valid || out_ready.
- While out_valid && !out_ready, out_data and out_ch are held bit-stable.
- FSM states: IDLE, SCAN.
- IDLE, mode=0 (direct):
  - On each load cycle: out_data <= dat[addr], out_ch <= addr, out_valid <= 1.
  - Latency is 1 cycle from addr/dat to out_data.
  - If addr >= CH: out_data <= 0, out_ch <= addr.
- IDLE, mode=1, no start:
  - On load, out_valid <= 0.
  - Output is otherwise idle.
- IDLE, mode=1, start=1:
  - Go to SCAN; cnt <= 0; busy <= 1.
  - In the same cycle, if load: present channel 0 (out_data <= dat[0], out_ch <= 0, out_valid <= 1, cnt <= 1).
- SCAN:
  - On each load cycle with cnt < CH: present dat[cnt], then cnt++.
  - When the transfer of channel CH-1 completes (valid && ready && out_ch == CH-1):
    - Next cycle: out_valid=0 (unless start re-launches), busy=0, done=1 for exactly one cycle.
    - State returns to IDLE.
  - Data is sampled at the load cycle, not at the accept cycle.
- start while busy: ignored.
- mode changes during SCAN: ignored until IDLE.
- Throughput: one channel per cycle with out_ready held high. A full scan is CH transfers and takes CH cycles after start, plus the done cycle.
- Counter width: AW bits plus one terminal flag. There is no wrap-around; the scan never restarts on its own.

Optional Feature:
- Macro: SCAN_DATA_SELECTOR_CH_MASK_EN.
- Defined:
  - Adds input port ch_mask [CH-1:0]; 1 = channel enabled.
  - Scan skips disabled channels. The next index is the lowest enabled index > current, found combinationally.
  - The last transfer is the highest enabled channel.
  - If ch_mask == 0 at start: no transfers, busy pulses one cycle, then done.
  - Direct mode with a disabled channel outputs out_data=0.
  - ch_mask is sampled continuously; the team's rule is to hold it stable during a scan.
- Undefined: port absent; all CH channels are always enabled.

Decomposition:
- Shared package scan_sel_pkg: state enum (IDLE, SCAN), MODE_DIRECT/MODE_SCAN constants, and a function for AW (min 1).
- One sub-module, chan_mux: combinational CH:1 × W selector with an out-of-range zero output. Instantiated once, indexed by either addr or the scan counter.

Test Plan:
- Reset mid-scan: CH=8, W=8, start scan, assert rst at transfer 3 → all outputs 0 immediately, no done, next start rescans from channel 0.
- Direct mode: dat = {8'h77,...,8'h00} (channel k = k×0x11), addr=5, out_ready=1 → next cycle out_data=0x55, out_ch=5, out_valid=1; addr=9 with CH=10 → channel 9 value; CH=8, addr width 3 → covered.
- Full-rate scan: mode=1, start pulse, out_ready=1 → out_ch 0..7 on 8 consecutive cycles with out_data = k×0x11, done=1 on cycle 9, busy low.
- Backpressure: out_ready=0 for 4 cycles while out_ch=2 → out_data=0x22 held stable; on release, 3 follows next cycle; total transfers exactly 8.
- start during SCAN and mode toggle mid-scan → ignored; sequence and done timing unchanged.
- CH_MASK_EN: ch_mask=8'b1010_0101 → scan emits channels 0, 2, 5, 7 only, then done; ch_mask=0 → done 2 cycles after start, out_valid never asserted.

Source files
------------

// File: rtl/scan_sel_pkg.sv
// Shared types and helpers for the scan data selector.
package scan_sel_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Channel-index width; never narrower than one bit.
  function automatic int aw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_data_selector_chan_mux.sv
// Combinational CH:1 selector of W-bit channels; any select >= CH yields zero.
module chan_mux #(
  parameter int CH = 8,
  parameter int W  = 8,
  parameter int SW = 4
) (
  input  logic [CH*W-1:0] dat,
  input  logic [SW-1:0]   sel,
  output logic [W-1:0]    q
);

  always_comb begin
    q = '0;
    for (int k = 0; k < CH; k++)
      if (sel == SW'(k)) q = dat[k*W +: W];
  end

endmodule

// File: rtl/scan_data_selector.sv
// Parametrised CH x W channel selector with registered valid/ready output and
// direct/scan modes. Optional channel mask: SCAN_DATA_SELECTOR_CH_MASK_EN.
module scan_data_selector
  import scan_sel_pkg::*;
#(
  parameter  int CH = 8,
  parameter  int W  = 8,
  localparam int AW = aw_f(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*W-1:0] dat,
  input  logic [AW-1:0]   addr,
  input  logic            mode,
  input  logic            start,
  output logic [W-1:0]    out_data,
  output logic [AW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done
`ifdef SCAN_DATA_SELECTOR_CH_MASK_EN
  ,
  input  logic [CH-1:0]   ch_mask
`endif
);

  // Counter carries one extra bit so the value CH marks "nothing left".
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] CH_C = CW'(CH);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] base, scan_idx, sel;
  logic [W-1:0]  mux_data, direct_data, data_nx;
  logic [AW-1:0] ch_nx;
  logic          valid_nx, busy_nx, done_nx;
  logic          load, scan_go, term;

  assign load    = !out_valid || out_ready;
  assign scan_go = (state == IDLE) && (mode == MODE_SCAN) && start;

  // Next channel to present: the lowest enabled index at or above base.
  always_comb begin
    base = (state == SCAN) ? cnt : '0;
`ifdef SCAN_DATA_SELECTOR_CH_MASK_EN
    scan_idx = CH_C;
    for (int i = CH - 1; i >= 0; i--)
      if (ch_mask[i] && (CW'(i) >= base)) scan_idx = CW'(i);
`else
    scan_idx = (base < CH_C) ? base : CH_C;
`endif
  end

  assign term = (scan_idx == CH_C);
  assign sel  = ((state == SCAN) || scan_go) ? scan_idx : {1'b0, addr};

  chan_mux #(
    .CH (CH),
    .W  (W),
    .SW (CW)
  ) u_mux (
    .dat (dat),
    .sel (sel),
    .q   (mux_data)
  );

`ifdef SCAN_DATA_SELECTOR_CH_MASK_EN
  logic addr_en;
  always_comb begin
    addr_en = 1'b0;
    for (int k = 0; k < CH; k++)
      if (addr == AW'(k)) addr_en = ch_mask[k];
  end
  assign direct_data = addr_en ? mux_data : '0;
`else
  assign direct_data = mux_data;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    data_nx  = out_data;
    ch_nx    = out_ch;
    valid_nx = out_valid;
    busy_nx  = busy;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (mode == MODE_DIRECT) begin
          if (load) begin
            data_nx  = direct_data;
            ch_nx    = addr;
            valid_nx = 1'b1;
          end
        end else if (start) begin
          state_nx = SCAN;
          busy_nx  = 1'b1;
          cnt_nx   = '0;
          if (load) begin
            if (term) begin
              valid_nx = 1'b0;
              cnt_nx   = scan_idx;
            end else begin
              data_nx  = mux_data;
              ch_nx    = scan_idx[AW-1:0];
              valid_nx = 1'b1;
              cnt_nx   = scan_idx + CW'(1);
            end
          end
        end else if (load) begin
          valid_nx = 1'b0;
        end
      end
      SCAN: begin
        // With nothing left to present, the next load means the last
        // transfer (if any) was just accepted.
        if (load) begin
          if (term) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            valid_nx = 1'b0;
            cnt_nx   = '0;
          end else begin
            data_nx  = mux_data;
            ch_nx    = scan_idx[AW-1:0];
            valid_nx = 1'b1;
            cnt_nx   = scan_idx + CW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      out_data  <= data_nx;
      out_ch    <= ch_nx;
      out_valid <= valid_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_scan_data_selector.sv
// Bench for scan_data_selector: queue-based reference model, per-cycle compare,
// directed literal checks and a randomized phase. Honours SCAN_DATA_SELECTOR_CH_MASK_EN.
module tb_scan_data_selector;

  localparam int CH = 8;
  localparam int W  = 8;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [CH*W-1:0] dat = '0;
  logic [AW-1:0]   addr = '0;
  logic            mode = 1'b0;
  logic            start = 1'b0;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_data;
  logic [AW-1:0]   out_ch;
  logic            out_valid, busy, done;
`ifdef SCAN_DATA_SELECTOR_CH_MASK_EN
  logic [CH-1:0]   ch_mask = '1;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  scan_data_selector #(.CH(CH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .dat       (dat),
    .addr      (addr),
    .mode      (mode),
    .start     (start),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef SCAN_DATA_SELECTOR_CH_MASK_EN
    ,
    .ch_mask   (ch_mask)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit en(input int k);
`ifdef SCAN_DATA_SELECTOR_CH_MASK_EN
    return ch_mask[k];
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [W-1:0] chv(input int k);
    if (k < CH && en(k)) return dat[k*W +: W];
    return '0;
  endfunction

  bit           m_valid = 0, m_busy = 0, m_done = 0, m_scan = 0;
  logic [W-1:0] m_data = '0;
  int           m_ch = 0;
  int           pend[$];

  task automatic present_next();
    int k;
    if (pend.size() == 0) m_valid = 0;
    else begin
      k = pend.pop_front();
      m_data  = chv(k);
      m_ch    = k;
      m_valid = 1;
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    bit load;
    if (rst) begin
      m_valid = 0; m_data = '0; m_ch = 0; m_busy = 0; m_done = 0; m_scan = 0;
      pend.delete();
    end else begin
      load   = !m_valid || out_ready;
      m_done = 0;
      if (!m_scan) begin
        if (mode == 1'b0) begin
          if (load) begin
            m_data  = chv(int'(addr));
            m_ch    = int'(addr);
            m_valid = 1;
          end
        end else if (start) begin
          m_scan = 1;
          m_busy = 1;
          pend.delete();
          for (int k = 0; k < CH; k++) if (en(k)) pend.push_back(k);
          if (load) present_next();
        end else if (load) begin
          m_valid = 0;
        end
      end else if (load) begin
        if (pend.size() == 0) begin
          m_scan = 0; m_busy = 0; m_done = 1; m_valid = 0;
        end else present_next();
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("m.out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("m.out_data", out_data, m_data);
      check("m.out_ch", out_ch, m_ch);
    end
    check("m.busy", busy, m_busy);
    check("m.done", done, m_done);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < CH; k++) dat[k*W +: W] = W'(k * 8'h11);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int xfers, stall;
    bit seen_done;
    #1 rst = 1'b1;
    tick();
    check("rst.out_data", out_data, 0);
    check("rst.out_ch", out_ch, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    #2 rst = 1'b0;

    // direct mode
    load_ramp();
    mode = 1'b0; addr = 3'd5; out_ready = 1'b1;
    tick();
    check("dir5.data", out_data, 8'h55);
    check("dir5.ch", out_ch, 5);
    check("dir5.valid", out_valid, 1);
    addr = 3'd3;
    tick();
    check("dir3.data", out_data, 8'h33);

    // full-rate scan, with start/mode noise mid-scan
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < CH; k++) begin
      check("scan.ch", out_ch, k);
      check("scan.data", out_data, k * 8'h11);
      check("scan.busy", busy, 1);
      if (k == 3) begin start = 1'b1; mode = 1'b0; end
      if (k == 4) begin start = 1'b0; mode = 1'b1; end
      tick();
    end
    check("scan.done", done, 1);
    check("scan.busy_end", busy, 0);
    check("scan.valid_end", out_valid, 0);
    tick();
    check("scan.done_pulse", done, 0);

    // backpressure on channel 2
    start = 1'b1;
    tick();
    start = 1'b0;
    xfers = 0; stall = 0; seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin seen_done = 1; break; end
      if (out_valid && out_ch == 3'd2 && stall < 4) begin
        out_ready = 1'b0;
        check("bp.hold", out_data, 8'h22);
        stall++;
      end else out_ready = 1'b1;
      if (out_valid && out_ready) xfers++;
      tick();
    end
    check("bp.stall", stall, 4);
    check("bp.xfers", xfers, CH);
    check("bp.done", seen_done, 1);
    out_ready = 1'b1;

    // reset in the middle of a scan
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("mid.ch3", out_ch, 3);
    #2 rst = 1'b1;
    #1;
    check("mid.rst_valid", out_valid, 0);
    check("mid.rst_data", out_data, 0);
    check("mid.rst_ch", out_ch, 0);
    check("mid.rst_busy", busy, 0);
    check("mid.rst_done", done, 0);
    tick();
    #2 rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mid.rescan_ch", out_ch, 0);
    check("mid.rescan_data", out_data, 8'h00);
    check("mid.rescan_busy", busy, 1);
    seen_done = 0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      tick();
      if (done) seen_done = 1;
    end
    check("mid.rescan_done", seen_done, 1);

`ifdef SCAN_DATA_SELECTOR_CH_MASK_EN
    begin : mask_tests
      int exp_ch[4];
      exp_ch = '{0, 2, 5, 7};
      ch_mask = 8'b1010_0101;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        check("mask.ch", out_ch, exp_ch[i]);
        check("mask.data", out_data, exp_ch[i] * 8'h11);
        tick();
      end
      check("mask.done", done, 1);
      mode = 1'b0; addr = 3'd1;
      tick();
      check("mask.dir_off", out_data, 8'h00);
      check("mask.dir_ch", out_ch, 1);
      mode = 1'b1; ch_mask = '0; start = 1'b1;
      tick();
      start = 1'b0;
      check("mask0.busy", busy, 1);
      check("mask0.valid", out_valid, 0);
      tick();
      check("mask0.done", done, 1);
      check("mask0.valid2", out_valid, 0);
      check("mask0.busy2", busy, 0);
      ch_mask = '1;
      tick();
    end
`endif

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      dat  = {$urandom, $urandom};
      addr = AW'($urandom_range(0, CH - 1));
      mode = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef SCAN_DATA_SELECTOR_CH_MASK_EN
      if (!busy) ch_mask = CH'($urandom);
`endif
      if ($urandom_range(0, 299) == 0) #2 rst = 1'b1;
      else if (rst) #2 rst = 1'b0;
      tick();
    end
    #2 rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
